sprite_blitter: RTL and testbench

Sprite blitter that consumes the object table's (id -> h, w, addr) lookup. It walks every pixel of the selected sprite in the sprite ROM and writes opaque, on-screen pixels into the framebuffer at a requested screen position. It sits between the game-logic draw scheduler (the request side) and the `Object` table, sprite ROM and framebuffer BRAM (the lookup and data side). One sprite is drawn per request, one pixel per clock.

---
 rtl/sprite_blitter.sv | 166 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks an object-table sprite in the ROM one pixel per clock and
// writes opaque, on-screen pixels into the framebuffer at the requested position.
module sprite_blitter #(
  parameter int          SCREEN_W    = 640,
  parameter int          SCREEN_H    = 480,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_id,
  input  logic [10:0] req_x,
  input  logic [10:0] req_y,
  output logic [5:0]  obj_id,
  input  logic [10:0] obj_h,
  input  logic [10:0] obj_w,
  input  logic [18:0] obj_addr,
  output logic [18:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic        fb_we,
  output logic [10:0] fb_x,
  output logic [10:0] fb_y,
  output logic [11:0] fb_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t      state_r;
  logic [5:0]  id_r;
  logic [10:0] x_r;
  logic [10:0] y_r;
  logic [10:0] h_r;
  logic [10:0] w_r;
  logic [10:0] col_r;
  logic [10:0] row_r;
  logic [18:0] rom_addr_r;
  logic        pipe_valid_r;
  logic [11:0] pipe_px_r;
  logic [11:0] pipe_py_r;
  logic        ready_r;
  logic        done_r;

  logic        last_col_s;
  logic        last_row_s;
  logic [11:0] px_s;
  logic [11:0] py_s;
  logic        visible_s;

  // Raster position of the pixel being issued; 12 bits so a carry lands off-screen.
  always_comb begin
    last_col_s = (col_r == (w_r - 11'd1));
    last_row_s = (row_r == (h_r - 11'd1));
    px_s       = {1'b0, x_r} + {1'b0, col_r};
    py_s       = {1'b0, y_r} + {1'b0, row_r};
  end

  // Write stage lines up with the ROM's one-cycle read latency.
  always_comb begin
    visible_s = 1'b0;
    if (pipe_valid_r && (rom_data != TRANSPARENT) &&
        (pipe_px_r < 12'(SCREEN_W)) && (pipe_py_r < 12'(SCREEN_H))) begin
      visible_s = 1'b1;
    end else begin
      visible_s = 1'b0;
    end
  end

  // Request handshake, table lookup, raster walk and completion sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      id_r         <= 6'd0;
      x_r          <= 11'd0;
      y_r          <= 11'd0;
      h_r          <= 11'd0;
      w_r          <= 11'd0;
      col_r        <= 11'd0;
      row_r        <= 11'd0;
      rom_addr_r   <= 19'd0;
      pipe_valid_r <= 1'b0;
      pipe_px_r    <= 12'd0;
      pipe_py_r    <= 12'd0;
      ready_r      <= 1'b1;
      done_r       <= 1'b0;
    end else begin
      pipe_valid_r <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b1;
          if (req_valid) begin
            id_r    <= req_id;
            x_r     <= req_x;
            y_r     <= req_y;
            ready_r <= 1'b0;
            state_r <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          h_r   <= obj_h;
          w_r   <= obj_w;
          col_r <= 11'd0;
          row_r <= 11'd0;
          if ((obj_h == 11'd0) || (obj_w == 11'd0)) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            rom_addr_r <= obj_addr;
            state_r    <= ST_RUN;
          end
        end
        ST_RUN: begin
          pipe_valid_r <= 1'b1;
          pipe_px_r    <= px_s;
          pipe_py_r    <= py_s;
          if (last_col_s) begin
            col_r <= 11'd0;
            if (last_row_s) begin
              state_r <= ST_DRAIN;
            end else begin
              row_r <= row_r + 11'd1;
            end
          end else begin
            col_r <= col_r + 11'd1;
          end
          // Running address replaces base + row*w + col; wraps naturally at 19 bits.
          if (!(last_col_s && last_row_s)) begin
            rom_addr_r <= rom_addr_r + 19'd1;
          end
        end
        ST_DRAIN: begin
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_r;
  assign busy      = ~ready_r;
  assign done      = done_r;
  assign obj_id    = id_r;
  assign rom_addr  = rom_addr_r;
  assign fb_we     = visible_s;
  assign fb_x      = pipe_px_r[10:0];
  assign fb_y      = pipe_py_r[10:0];
  assign fb_data   = pipe_valid_r ? rom_data : 12'd0;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: vector table plus scoreboard queues of
// expected ROM reads, framebuffer writes and done pulses, keyed by absolute cycle.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_id;
  logic [10:0] req_x;
  logic [10:0] req_y;
  logic [5:0]  obj_id;
  logic [10:0] obj_h;
  logic [10:0] obj_w;
  logic [18:0] obj_addr;
  logic [18:0] rom_addr;
  logic [11:0] rom_data;
  logic        fb_we;
  logic [10:0] fb_x;
  logic [10:0] fb_y;
  logic [11:0] fb_data;
  logic        busy;
  logic        done;

  sprite_blitter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_x(req_x), .req_y(req_y),
    .obj_id(obj_id), .obj_h(obj_h), .obj_w(obj_w), .obj_addr(obj_addr),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [18:0] NO_TRANS = 19'h40000;

  typedef struct { int cyc; logic [10:0] x; logic [10:0] y; logic [11:0] d; } wr_t;
  typedef struct { int cyc; logic [18:0] a; } rd_t;
  typedef struct {
    logic [5:0]  id;
    logic [10:0] x;
    logic [10:0] y;
    logic [18:0] tr;
    int          wr;
    int          dn;
  } vec_t;

  wr_t wq[$];
  rd_t rq[$];
  int  dq[$];

  logic [10:0] tab_h [64];
  logic [10:0] tab_w [64];
  logic [18:0] tab_a [64];
  logic [18:0] trans_addr = NO_TRANS;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int n_wr = 0;

  assign obj_h    = tab_h[obj_id];
  assign obj_w    = tab_w[obj_id];
  assign obj_addr = tab_a[obj_id];

  function automatic logic [11:0] rom_fn(input logic [18:0] a);
    logic [11:0] v;
    v = a[11:0] + 12'h123;
    if (v == 12'hF0F) v = 12'h000;
    if (a == trans_addr) v = 12'hF0F;
    return v;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score whatever the DUT produced this cycle.
  task automatic tick();
    wr_t e;
    rd_t r;
    int  d;
    @(negedge clk);
    if (rst_n) begin
      if (fb_we) begin
        n_wr++;
        if (wq.size() == 0) begin
          chk(1'b0, "unexpected_write", {30'd0, fb_x, fb_y, fb_data}, 64'd0);
        end else begin
          e = wq.pop_front();
          chk((e.cyc == cyc) && (fb_x == e.x) && (fb_y == e.y) && (fb_data == e.d), "write",
              {cyc[15:0], 14'd0, fb_x, fb_y, fb_data}, {e.cyc[15:0], 14'd0, e.x, e.y, e.d});
        end
      end else if ((wq.size() > 0) && (wq[0].cyc <= cyc)) begin
        e = wq.pop_front();
        chk(1'b0, "missing_write", 64'(cyc), {e.cyc[15:0], 14'd0, e.x, e.y, e.d});
      end
      if ((rq.size() > 0) && (rq[0].cyc <= cyc)) begin
        r = rq.pop_front();
        chk((r.cyc == cyc) && (rom_addr == r.a), "rom_addr",
            {cyc[15:0], 29'd0, rom_addr}, {r.cyc[15:0], 29'd0, r.a});
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk(1'b0, "unexpected_done", 64'(cyc), 64'd0);
        end else begin
          d = dq.pop_front();
          chk(d == cyc, "done_cycle", 64'(cyc), 64'(d));
        end
      end else if ((dq.size() > 0) && (dq[0] < cyc)) begin
        d = dq.pop_front();
        chk(1'b0, "missing_done", 64'(cyc), 64'(d));
      end
    end
  endtask

  // Reference walk of one sprite: ROM reads from cycle 2, writes from cycle 3.
  task automatic push_expect(input logic [5:0] id, input logic [10:0] x, input logic [10:0] y, input int t0);
    int h, w, i;
    logic [18:0] ra;
    logic [11:0] px, py, d;
    h = int'(tab_h[id]);
    w = int'(tab_w[id]);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        i  = r * w + c;
        ra = tab_a[id] + 19'(i);
        rq.push_back('{t0 + 2 + i, ra});
        px = {1'b0, x} + 12'(c);
        py = {1'b0, y} + 12'(r);
        d  = rom_fn(ra);
        if ((d != 12'hF0F) && (px < 12'd640) && (py < 12'd480))
          wq.push_back('{t0 + 3 + i, px[10:0], py[10:0], d});
      end
    end
  endtask

  task automatic start_req(input vec_t v, input bit hold, output int t0, output logic [18:0] ra0, output int snap);
    trans_addr = v.tr;
    req_id     = v.id;
    req_x      = v.x;
    req_y      = v.y;
    req_valid  = 1'b1;
    chk(req_ready == 1'b1, "ready_idle", 64'(req_ready), 64'd1);
    t0   = cyc;
    ra0  = rom_addr;
    snap = n_wr;
    push_expect(v.id, v.x, v.y, t0);
    dq.push_back(t0 + v.dn);
    tick();
    if (!hold) req_valid = 1'b0;
    chk(busy == 1'b1, "busy_lookup", 64'(busy), 64'd1);
  endtask

  task automatic finish_req(input vec_t v, input int t0, input logic [18:0] ra0, input int snap);
    int k;
    if (int'(tab_h[v.id]) * int'(tab_w[v.id]) == 0) begin
      chk(rom_addr == ra0, "zero_rom_c1", 64'(rom_addr), 64'(ra0));
      tick();
      chk(rom_addr == ra0, "zero_rom_c2", 64'(rom_addr), 64'(ra0));
    end
    k = 0;
    while (!req_ready && (k < 200)) begin
      tick();
      k++;
    end
    chk(req_ready && (cyc == t0 + v.dn + 1), "ready_back", 64'(cyc - t0), 64'(v.dn + 1));
    chk((wq.size() + rq.size() + dq.size()) == 0, "queues_empty",
        64'(wq.size() + rq.size() + dq.size()), 64'd0);
    chk((n_wr - snap) == v.wr, "write_count", 64'(n_wr - snap), 64'(v.wr));
  endtask

  vec_t vt[8];
  vec_t vb;
  vec_t vr;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tb, snap, k;
    logic [18:0] ra0;

    for (int i = 0; i < 64; i++) begin
      tab_h[i] = 11'd0;
      tab_w[i] = 11'd0;
      tab_a[i] = 19'd0;
    end
    tab_h[1] = 11'd2;  tab_w[1] = 11'd3;  tab_a[1] = 19'd100;
    tab_h[2] = 11'd2;  tab_w[2] = 11'd4;  tab_a[2] = 19'd200;
    tab_h[4] = 11'd0;  tab_w[4] = 11'd5;  tab_a[4] = 19'd400;
    tab_h[5] = 11'd1;  tab_w[5] = 11'd1;  tab_a[5] = 19'h7FFFF;
    tab_h[6] = 11'd3;  tab_w[6] = 11'd0;  tab_a[6] = 19'd500;
    tab_h[7] = 11'd4;  tab_w[7] = 11'd4;  tab_a[7] = 19'd600;
    tab_h[63] = 11'd3; tab_w[63] = 11'd2; tab_a[63] = 19'h7FFFE;

    vt[0] = '{6'd1,  11'd10,   11'd20,  NO_TRANS, 6, 9};
    vt[1] = '{6'd1,  11'd10,   11'd20,  19'd102,  5, 9};
    vt[2] = '{6'd2,  11'd638,  11'd479, NO_TRANS, 2, 11};
    vt[3] = '{6'd2,  11'd2046, 11'd10,  NO_TRANS, 0, 11};
    vt[4] = '{6'd4,  11'd0,    11'd0,   NO_TRANS, 0, 2};
    vt[5] = '{6'd6,  11'd5,    11'd5,   NO_TRANS, 0, 2};
    vt[6] = '{6'd5,  11'd0,    11'd0,   NO_TRANS, 1, 4};
    vt[7] = '{6'd63, 11'd639,  11'd0,   NO_TRANS, 3, 9};

    req_valid = 1'b0;
    req_id    = 6'd0;
    req_x     = 11'd0;
    req_y     = 11'd0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk(req_ready == 1'b1, "rst_ready", 64'(req_ready), 64'd1);
    chk({busy, done, fb_we} == 3'b000, "rst_busy_done_we", 64'({busy, done, fb_we}), 64'd0);
    chk({rom_addr, obj_id} == 25'd0, "rst_rom_obj", 64'({rom_addr, obj_id}), 64'd0);
    chk({fb_x, fb_y, fb_data} == 34'd0, "rst_fb", 64'({fb_x, fb_y, fb_data}), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      start_req(vt[i], 1'b0, t0, ra0, snap);
      finish_req(vt[i], t0, ra0, snap);
      tick();
    end

    // Back-to-back: valid held high, fields changed while busy must not disturb the sprite.
    trans_addr = NO_TRANS;
    vb = '{6'd5, 11'd30, 11'd40, NO_TRANS, 1, 4};
    start_req(vt[0], 1'b1, t0, ra0, snap);
    req_id = vb.id;
    req_x  = vb.x;
    req_y  = vb.y;
    tb = t0 + 10;
    push_expect(vb.id, vb.x, vb.y, tb);
    dq.push_back(tb + vb.dn);
    k = 0;
    while (!req_ready && (k < 200)) begin
      tick();
      k++;
    end
    chk(cyc == tb, "b2b_handshake", 64'(cyc - t0), 64'd10);
    snap = n_wr;
    tick();
    req_valid = 1'b0;
    finish_req(vb, tb, ra0, snap);
    tick();

    // Reset in cycle 5 of a 4x4 sprite aborts it with no further writes or done.
    vr = '{6'd7, 11'd100, 11'd100, NO_TRANS, 0, 19};
    start_req(vr, 1'b0, t0, ra0, snap);
    k = 0;
    while ((cyc < t0 + 5) && (k < 50)) begin
      tick();
      k++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk({fb_we, done} == 2'b00, "midrst_we_done", 64'({fb_we, done}), 64'd0);
    chk({req_ready, busy} == 2'b10, "midrst_ready_busy", 64'({req_ready, busy}), 64'h2);
    wq.delete();
    rq.delete();
    dq.delete();
    tick();
    tick();
    rst_n = 1'b1;
    snap = n_wr;
    repeat (25) tick();
    chk(n_wr == snap, "post_rst_quiet", 64'(n_wr - snap), 64'd0);
    start_req(vt[0], 1'b0, t0, ra0, snap);
    finish_req(vt[0], t0, ra0, snap);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
